// File: rtl/led_pkg.sv
// Shared definitions for the LED status display blocks.
//   - mode_e       : display mode encoding used by led_status_ctl
//   - ST_*         : game FSM state codes driven into the LED controller
//   - DEF_LED_MAP  : default state -> LED index map (3 bits per state)
//   - DEF_BLINK_MASK : default set of states that blink after the flash
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STEADY = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_e;

  localparam int ST_IDLE  = 0;
  localparam int ST_PLAY  = 1;
  localparam int ST_STOP  = 2;
  localparam int ST_SCORE = 3;
  localparam int ST_SPEED = 4;
  localparam int ST_MISS  = 5;

  localparam int DEF_N_STATES = 6;
  localparam int DEF_IDX_W    = 3;

  // idle->0, play->2, stop->3, score->4, speed->1, miss->5
  localparam logic [DEF_N_STATES*DEF_IDX_W-1:0] DEF_LED_MAP = 18'b101_001_100_011_010_000;

  // Only the miss state keeps blinking after its change-flash.
  localparam logic [DEF_N_STATES-1:0] DEF_BLINK_MASK = 6'b100000;

endpackage

// File: rtl/led_tick_gen.sv
// Blink-phase prescaler shared by the display blocks.
//   clk  : system clock
//   rst  : synchronous active-high reset, counter returns to 0
//   clr  : synchronous restart of the count from 0 (takes effect at the edge)
//   tick : high for the one cycle in which the counter holds TICK_DIV-1
module led_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_status_ctl.sv
// Game-state LED controller.
// Lights one LED per game state. Every change to a valid state flashes the
// new state's LED for FLASH_TICKS blink phases; afterwards the LED holds
// steady, or keeps blinking when the state is flagged in BLINK_MASK.
// Invalid state codes turn all LEDs off without a flash.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   state    : current game FSM state code
//   en       : 1 = LEDs enabled, 0 = LEDs dark (tracking continues)
//   led      : registered LED drive, at most one bit set
//   flashing : registered, high while the change-flash is running
module led_status_ctl
  import led_pkg::*;
#(
  parameter int N_STATES    = 6,
  parameter int STATE_W     = 3,
  parameter int N_LED       = 6,
  parameter int IDX_W       = 3,
  parameter logic [N_STATES*IDX_W-1:0] LED_MAP    = DEF_LED_MAP,
  parameter logic [N_STATES-1:0]       BLINK_MASK = DEF_BLINK_MASK,
  parameter int TICK_DIV    = 25_000_000,
  parameter int FLASH_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic               en,
  output logic [N_LED-1:0]   led,
  output logic               flashing
);

  localparam int FL_W = $clog2(FLASH_TICKS + 1);

  // One-hot LED pattern for a state code; zero for invalid codes or map
  // entries that point past the last LED.
  function automatic logic [N_LED-1:0] decode(input logic [STATE_W-1:0] s);
    logic [N_LED-1:0] p;
    logic [IDX_W-1:0] idx;
    logic             hit;
    p   = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N_STATES; i++) begin
      if (s == STATE_W'(i)) begin
        idx = LED_MAP[IDX_W*i +: IDX_W];
        hit = 1'b1;
      end
    end
    if (hit) begin
      for (int j = 0; j < N_LED; j++) begin
        if (idx == IDX_W'(j)) p[j] = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic logic state_valid(input logic [STATE_W-1:0] s);
    return (int'(s) < N_STATES);
  endfunction

  function automatic logic blink_of(input logic [STATE_W-1:0] s);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N_STATES; i++) begin
      if (s == STATE_W'(i)) b = BLINK_MASK[i];
    end
    return b;
  endfunction

  logic [STATE_W-1:0] state_q, state_d;
  mode_e              mode_q, mode_d;
  logic               phase_q, phase_d;
  logic [FL_W-1:0]    flash_left_q, flash_left_d;
  logic [N_LED-1:0]   led_q, led_d;
  logic               flashing_q, flashing_d;

  logic               changed;
  logic               new_valid;
  logic               tick_clr;
  logic               tick;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign changed   = (state != state_q);
  assign new_valid = state_valid(state);
  // Restart the blink timebase on every valid change so the flash always
  // begins with a full-length lit phase.
  assign tick_clr  = changed && new_valid;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    phase_d      = phase_q;
    flash_left_d = flash_left_q;

    if (changed) begin
      // A change outranks a tick landing on the same edge.
      state_d = state;
      phase_d = 1'b1;
      if (new_valid) begin
        mode_d       = MODE_FLASH;
        flash_left_d = FL_W'(FLASH_TICKS);
      end else begin
        mode_d       = MODE_STEADY;
        flash_left_d = '0;
      end
    end else if (tick) begin
      case (mode_q)
        MODE_FLASH: begin
          if (flash_left_q == FL_W'(1)) begin
            mode_d       = blink_of(state_q) ? MODE_BLINK : MODE_STEADY;
            phase_d      = 1'b1;
            flash_left_d = '0;
          end else begin
            phase_d      = ~phase_q;
            flash_left_d = flash_left_q - FL_W'(1);
          end
        end
        MODE_BLINK: phase_d = ~phase_q;
        default:    phase_d = 1'b1;
      endcase
    end

    // Outputs are built from the next-state values so the LED follows a
    // state change with a single cycle of latency.
    led_d      = en ? (decode(state_d) & {N_LED{phase_d}}) : '0;
    flashing_d = (mode_d == MODE_FLASH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STATE_W'(ST_IDLE);
      mode_q       <= MODE_STEADY;
      phase_q      <= 1'b1;
      flash_left_q <= '0;
      led_q        <= '0;
      flashing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      flash_left_q <= flash_left_d;
      led_q        <= led_d;
      flashing_q   <= flashing_d;
    end
  end

  assign led      = led_q;
  assign flashing = flashing_q;

endmodule

// File: doc/led_status_ctl.md
Name: led_status_ctl

Overview:
Parametrised successor to the game-state LED decoder. It drives one LED per game state. On every state change it flashes the new state's LED for a fixed number of blink ticks, then holds it steady. States flagged in a mask blink continuously instead of holding steady. It sits between the top-level game FSM state register and the board LED pins, in the single system clock domain.

Parameters:
N_STATES, 6, number of valid state codes; codes >= N_STATES are invalid.
STATE_W, 3, width of state input; 2**STATE_W >= N_STATES.
N_LED, 6, number of LED outputs.
IDX_W, 3, width of one LED_MAP entry; 2**IDX_W >= N_LED.
LED_MAP, 18'b101_001_100_011_010_000, flat map; bits [IDX_W*s +: IDX_W] give the LED index for state s. The default gives idle->0, play->2, stop->3, score->4, speed->1, miss->5.
BLINK_MASK, 6'b100000, per-state bit; 1 = blink forever after the flash (default: miss).
TICK_DIV, 25_000_000, clk cycles per blink phase (4 Hz phase at 100 MHz); must be >= 2.
FLASH_TICKS, 4, phases in the change-flash; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
state  in  STATE_W  current game FSM state code
en  in  1  1 = LEDs enabled; 0 = LEDs forced dark, internal tracking continues
led  out  N_LED  registered LED drive, at most one bit set
flashing  out  1  registered; 1 while the change-flash is in progress

Behaviour:
- Reset (rst=1 at a clk edge):
  - state_q=0, mode=STEADY, phase=1, tick counter=0, flash_left=0, led=0, flashing=0.
  - First cycle after reset with state=0: no change is detected, and led shows the map of state 0.
- Decode:
  - pat = one-hot of LED_MAP[state_q] when state_q < N_STATES and map index < N_LED; otherwise pat = 0.
  - Invalid state: led=0; mode goes to STEADY immediately with no flash; flashing=0.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. tick=1 in the cycle the counter equals TICK_DIV-1.
- Change detect: at an edge where state != state_q and the new state is valid:
  - state_q<=state, mode<=FLASH, counter<=0, phase<=1, flash_left<=FLASH_TICKS.
  - led is updated at that same edge to the new pattern (1-cycle latency from state to led).
- FSM modes:
  - STEADY: phase held at 1; led=pat.
  - FLASH: each tick toggles phase and decrements flash_left. On the tick where flash_left==1, mode<=BLINK if BLINK_MASK[state_q] else STEADY, and phase<=1.
  - BLINK: phase toggles on every tick, indefinitely, until the next state change.
- Output: led <= en ? (pat & {N_LED{phase}}) : 0, registered every cycle. flashing <= (mode==FLASH), registered.
- Change during FLASH or BLINK: the flash restarts from the full FLASH_TICKS count with counter=0 and phase=1.
- Change coinciding with a tick: the change wins; the tick is discarded.
- en toggling: does not affect mode, phase or counters. led reflects en one cycle later.
- Reset mid-flash: all state is cleared per the reset values above; led=0 and flashing=0 in the next cycle.
- Counter width: $clog2(TICK_DIV). flash_left width: $clog2(FLASH_TICKS+1). No overflow is possible because both values are reloaded or saturate at their defined bounds.

Decomposition:
- Shared package led_pkg holds:
  - mode encoding: STEADY=2'd0, FLASH=2'd1, BLINK=2'd2;
  - game state codes: IDLE=0, PLAY=1, STOP=2, SCORE=3, SPEED=4, MISS=5;
  - the default LED_MAP and BLINK_MASK constants.
- Sub-module led_tick_gen: prescaler with a sync clear input and a tick output, parameter TICK_DIV. It is reused by other display blocks.

Test Plan:
All scenarios use bench parameters TICK_DIV=4, FLASH_TICKS=4 and en=1 unless stated.
1. Reset with state=0 held, then release -> next cycle led=6'b000001, flashing=0, and led stays constant for 50 cycles.
2. state 0->4 (speed) -> next cycle led=000010 with flashing=1; then led=000010 for 4 cycles, 000000 for 4, 000010 for 4, 000000 for 4; then 000010 steady with flashing=0, 16 cycles after the change.
3. state ->5 (miss) -> 16-cycle flash on 100000; then flashing=0 and led toggles 100000/000000 every 4 cycles indefinitely.
4. state 1 (led 000100) mid-flash changes to 2 at cycle 6 -> next cycle led=001000 and the flash restarts, ending 16 cycles after the second change. Then drive state=7 -> next cycle led=000000, flashing=0.
5. During state=3 steady, en=0 -> next cycle led=000000. en=1 -> next cycle led=010000, with no new flash.
6. rst=1 at cycle 9 of a flash -> next cycle led=000000, flashing=0. After release with state=3 held, a change from state_q=0 is detected and a fresh 16-cycle flash on 010000 starts.
